// File: rtl/hd44780_pkg.sv
// Shared types and constants for the HD44780 LCD interface blocks.
// Holds the bus-writer state enum, command byte constants, default timing
// (in cycles of the 500 kHz divided clock) and the long-execution classifier.
package hd44780_pkg;

  localparam int unsigned CLOCK_FREQ = 500000;

  // Default timing in clock cycles (2 us each at CLOCK_FREQ).
  localparam int unsigned T_SETUP_DEF     = 1;
  localparam int unsigned T_PULSE_DEF     = 1;
  localparam int unsigned T_HOLD_DEF      = 1;
  localparam int unsigned T_EXEC_DEF      = 19;   // 37 us
  localparam int unsigned T_EXEC_LONG_DEF = 760;  // 1.52 ms

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } state_e;

  // Clear Display (0x01) and Return Home (0x02/0x03, bit 0 is don't-care)
  // need the long execution wait; data writes never do.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME) ||
                   (b == (CMD_HOME | CMD_CLEAR)));
  endfunction

endpackage

// File: rtl/hd44780_delay_counter.sv
// Loadable down-counter used to time each bus phase.
// Ports:
//   clock      - rising-edge clock
//   reset      - asynchronous active-high reset, clears the count
//   load       - load load_value on the next edge (wins over counting)
//   load_value - value to load
//   zero       - count is 0 (combinational from the count register)
// The count stops at 0 and never wraps.
module hd44780_delay_counter #(
  parameter int unsigned W = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/hd44780_bus_writer.sv
// Physical-bus stage for an HD44780 LCD in 8-bit mode.
// Takes one instruction/data byte per valid/ready handshake, drives rs/db,
// strobes e with setup, pulse and hold timing, then waits out the LCD's
// execution time (no busy-flag polling) before accepting the next byte.
// Ports:
//   clock, reset        - divided clock; asynchronous active-high reset
//   in_valid/in_ready   - upstream handshake
//   in_rs, in_data      - register select and byte to write
//   done                - one-cycle pulse when a write and its exec wait end
//   rs, rw, e, db       - LCD pins (rw tied low, writes only)
module hd44780_bus_writer
  import hd44780_pkg::*;
#(
  parameter int unsigned T_SETUP     = T_SETUP_DEF,
  parameter int unsigned T_PULSE     = T_PULSE_DEF,
  parameter int unsigned T_HOLD      = T_HOLD_DEF,
  parameter int unsigned T_EXEC      = T_EXEC_DEF,
  parameter int unsigned T_EXEC_LONG = T_EXEC_LONG_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       done,
  output logic       rs,
  output logic       rw,
  output logic       e,
  output logic [7:0] db
);

  localparam int unsigned CNT_W = $clog2(T_EXEC_LONG + 1);

  state_e     state_q, state_d;
  logic       rs_q, rs_d;
  logic [7:0] db_q, db_d;
  logic       e_q, e_d;
  logic       in_ready_q, in_ready_d;
  logic       done_q, done_d;

  logic             cnt_load_c;
  logic [CNT_W-1:0] cnt_value_c;
  logic             cnt_zero_c;

  hd44780_delay_counter #(
    .W (CNT_W)
  ) u_delay (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load_c),
    .load_value (cnt_value_c),
    .zero       (cnt_zero_c)
  );

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rs_q       <= 1'b0;
      db_q       <= 8'h00;
      e_q        <= 1'b0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_q       <= rs_d;
      db_q       <= db_d;
      e_q        <= e_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
    end
  end

  // Next-state and next-output logic; each phase loads its length minus one.
  always_comb begin
    state_d     = state_q;
    rs_d        = rs_q;
    db_d        = db_q;
    e_d         = e_q;
    in_ready_d  = in_ready_q;
    done_d      = 1'b0;
    cnt_load_c  = 1'b0;
    cnt_value_c = '0;

    case (state_q)
      IDLE: begin
        e_d        = 1'b0;
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          rs_d        = in_rs;
          db_d        = in_data;
          in_ready_d  = 1'b0;
          cnt_load_c  = 1'b1;
          cnt_value_c = CNT_W'(T_SETUP - 1);
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (cnt_zero_c) begin
          e_d         = 1'b1;
          cnt_load_c  = 1'b1;
          cnt_value_c = CNT_W'(T_PULSE - 1);
          state_d     = PULSE;
        end
      end
      PULSE: begin
        if (cnt_zero_c) begin
          e_d         = 1'b0;
          cnt_load_c  = 1'b1;
          cnt_value_c = CNT_W'(T_HOLD - 1);
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (cnt_zero_c) begin
          cnt_load_c  = 1'b1;
          cnt_value_c = is_long_cmd(rs_q, db_q) ? CNT_W'(T_EXEC_LONG - 1)
                                                : CNT_W'(T_EXEC - 1);
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_zero_c) begin
          in_ready_d = 1'b1;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        e_d     = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready = in_ready_q;
  assign done     = done_q;
  assign rs       = rs_q;
  assign rw       = 1'b0;
  assign e        = e_q;
  assign db       = db_q;

endmodule

// File: tb/tb_hd44780_bus_writer.sv
// Directed self-checking bench for hd44780_bus_writer with default timing.
// Edge 0 is the accept edge; outputs are sampled 1 ns after each rising edge.
module tb_hd44780_bus_writer;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic       done;
  logic       rs;
  logic       rw;
  logic       e;
  logic [7:0] db;

  int errors = 0;
  int checks = 0;

  localparam int N_SHORT = 22;
  localparam int N_LONG  = 763;

  hd44780_bus_writer dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rs    (in_rs),
    .in_data  (in_data),
    .done     (done),
    .rs       (rs),
    .rw       (rw),
    .e        (e),
    .db       (db)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete write from idle; checks the pin sequence and done edge.
  task automatic run_byte(input string tag, input logic r, input logic [7:0] d,
                          input int exp_n);
    int k;
    int pulses;
    in_rs    = r;
    in_data  = d;
    in_valid = 1'b1;
    tick();                                   // edge 0
    in_valid = 1'b0;
    in_rs    = ~r;
    in_data  = ~d;
    check({tag, "_rs0"}, 32'(rs), 32'(r));
    check({tag, "_db0"}, 32'(db), 32'(d));
    check({tag, "_e0"}, 32'(e), 32'd0);
    check({tag, "_rdy0"}, 32'(in_ready), 32'd0);
    tick();                                   // edge 1
    check({tag, "_e1"}, 32'(e), 32'd1);
    tick();                                   // edge 2
    check({tag, "_e2"}, 32'(e), 32'd0);
    check({tag, "_db2"}, 32'(db), 32'(d));
    k = 2;
    pulses = 0;
    while (!done && k < 2000) begin
      tick();
      k++;
      if (e) pulses++;
    end
    check({tag, "_done_edge"}, 32'(k), 32'(exp_n));
    check({tag, "_rdy_done"}, 32'(in_ready), 32'd1);
    check({tag, "_wait_e"}, 32'(pulses), 32'd0);
    check({tag, "_rw"}, 32'(rw), 32'd0);
    tick();
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    int k;
    int dones;
    int rises;
    int bad_db;
    int idx;
    int cur_t;
    logic e_prev;
    logic prev_ready;
    logic [7:0] cur;
    logic [7:0] seq [3];
    int acc_t [3];

    seq[0] = 8'h38;
    seq[1] = 8'h0C;
    seq[2] = 8'h06;
    for (int i = 0; i < 3; i++) acc_t[i] = -1;

    // Reset values and first in_ready.
    reset    = 1'b1;
    in_valid = 1'b0;
    in_rs    = 1'b0;
    in_data  = 8'h00;
    tick();
    tick();
    check("rst_rs", 32'(rs), 32'd0);
    check("rst_rw", 32'(rw), 32'd0);
    check("rst_e", 32'(e), 32'd0);
    check("rst_db", 32'(db), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    #1;
    check("rel_rdy_before_edge", 32'(in_ready), 32'd0);
    tick();
    check("rel_rdy_after_edge", 32'(in_ready), 32'd1);

    // Reset asserted while e is high.
    in_rs    = 1'b1;
    in_data  = 8'h41;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("midrst_e_high", 32'(e), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_e", 32'(e), 32'd0);
    check("midrst_rs", 32'(rs), 32'd0);
    check("midrst_db", 32'(db), 32'd0);
    check("midrst_rdy", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    check("midrst_rdy_held", 32'(in_ready), 32'd0);
    dones = 0;
    tick();
    check("midrst_rdy_release", 32'(in_ready), 32'd1);
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      tick();
    end
    check("midrst_no_done", 32'(dones), 32'd0);

    // Single writes: data, long commands, normal commands.
    run_byte("data41", 1'b1, 8'h41, N_SHORT);
    run_byte("clear", 1'b0, 8'h01, N_LONG);
    run_byte("home02", 1'b0, 8'h02, N_LONG);
    run_byte("home03", 1'b0, 8'h03, N_LONG);
    run_byte("cmd04", 1'b0, 8'h04, N_SHORT);
    run_byte("cmd38", 1'b0, 8'h38, N_SHORT);
    run_byte("data01", 1'b1, 8'h01, N_SHORT);

    // Back-to-back with in_valid held high.
    in_rs      = 1'b0;
    in_data    = seq[0];
    in_valid   = 1'b1;
    idx        = 0;
    cur        = 8'h00;
    cur_t      = 0;
    rises      = 0;
    e_prev     = 1'b0;
    prev_ready = in_ready;
    for (int t = 0; t < 90; t++) begin
      tick();
      if (e && !e_prev) rises++;
      e_prev = e;
      if (prev_ready && !in_ready) begin
        if (idx < 3) begin
          acc_t[idx] = t;
          cur        = seq[idx];
          cur_t      = t;
        end
        idx++;
        if (idx < 3) in_data = seq[idx];
        else in_valid = 1'b0;
      end
      if (idx > 0 && idx <= 3 && (t - cur_t) <= 3) check("b2b_db_stable", 32'(db), 32'(cur));
      prev_ready = in_ready;
    end
    in_valid = 1'b0;
    check("b2b_accepts", 32'(idx), 32'd3);
    check("b2b_acc0", 32'(acc_t[0]), 32'd0);
    check("b2b_acc1", 32'(acc_t[1]), 32'd23);
    check("b2b_acc2", 32'(acc_t[2]), 32'd46);
    check("b2b_e_pulses", 32'(rises), 32'd3);

    // Input activity during WAIT must be ignored.
    in_rs    = 1'b1;
    in_data  = 8'h41;
    in_valid = 1'b1;
    tick();                                   // edge 0
    in_valid = 1'b0;
    tick();
    tick();
    tick();                                   // edge 3, now waiting
    k      = 3;
    rises  = 0;
    bad_db = 0;
    e_prev = e;
    while (!done && k < 200) begin
      if (k < 15) begin
        in_valid = k[0];
        in_data  = 8'(k * 17);
        in_rs    = ~k[1];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      k++;
      if (e && !e_prev) rises++;
      e_prev = e;
      if (db !== 8'h41) bad_db++;
    end
    check("waitio_done_edge", 32'(k), 32'(N_SHORT));
    check("waitio_e_pulses", 32'(rises), 32'd0);
    check("waitio_db_bad_cycles", 32'(bad_db), 32'd0);
    check("waitio_rs", 32'(rs), 32'd1);
    tick();
    check("waitio_idle_rdy", 32'(in_ready), 32'd1);
    check("waitio_idle_e", 32'(e), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hd44780_bus_writer.md
Name: hd44780_bus_writer

Overview:
- Physical-bus stage directly downstream of the hd44780 controller.
- Accepts one command or data byte per valid/ready handshake and drives the HD44780 pins (rs, rw, e, db) with legal setup, enable-pulse and hold timing.
- Holds off the next byte until the LCD's execution time has elapsed; busy-flag polling is not used.
- Runs on the same divided 500 kHz clock as the controller (2 us per cycle).

Parameters:
- T_SETUP, 1, cycles rs/db are stable before e rises (tAS); must be >= 1.
- T_PULSE, 1, cycles e is held high (PWEH); must be >= 1.
- T_HOLD, 1, cycles rs/db are held after e falls (tH); must be >= 1.
- T_EXEC, 19, wait cycles after a normal instruction or data write (37 us at 500 kHz); must be >= 1.
- T_EXEC_LONG, 760, wait cycles after Clear Display or Return Home (1.52 ms); must be >= T_EXEC.

Ports:
- clock  in  1  divided system clock, rising-edge.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream has a byte.
- in_ready  out  1  block can accept a byte.
- in_rs  in  1  0 = instruction, 1 = data.
- in_data  in  8  byte to write.
- done  out  1  one-cycle pulse when a write, including its exec wait, completes.
- rs  out  1  LCD register select.
- rw  out  1  LCD read/write; always 0.
- e  out  1  LCD enable strobe.
- db  out  8  LCD data bus, 8-bit mode.

Behaviour:
- All outputs are registered. Reset is asynchronous and active-high; while reset is asserted: rs=0, rw=0, e=0, db=0, in_ready=0, done=0, state=IDLE, counter=0.
- in_ready rises on the first clock edge after reset deasserts.
- States: IDLE -> SETUP -> PULSE -> HOLD -> WAIT -> IDLE.
- IDLE: in_ready=1, e=0. On an edge with in_valid&in_ready, the block:
  - latches in_rs/in_data into rs/db;
  - clears in_ready;
  - loads the counter with T_SETUP-1;
  - enters SETUP.
- Once accepted, later changes on in_rs/in_data have no effect. in_valid while in_ready=0 is ignored; no byte is queued.
- SETUP: e=0. When the counter reaches 0, set e=1, load T_PULSE-1, go to PULSE.
- PULSE: e=1. When the counter reaches 0, set e=0, load T_HOLD-1, go to HOLD.
- HOLD: e=0, rs/db held. When the counter reaches 0, load the exec wait minus 1 and go to WAIT.
  - Exec wait is T_EXEC_LONG if the latched rs=0 and db[7:1]==7'b0000000 with db!=0 (i.e. 0x01, 0x02, 0x03).
  - Otherwise the exec wait is T_EXEC.
- WAIT: rs/db keep their last value. When the counter reaches 0, set in_ready=1, pulse done=1 for one cycle, go to IDLE.
- Counter is a down-counter of width $clog2(T_EXEC_LONG+1) and never wraps.
- Timing, with edge 0 being the accept edge:
  - e rises at edge T_SETUP.
  - e falls at edge T_SETUP+T_PULSE.
  - done=1 and in_ready=1 at edge N = T_SETUP+T_PULSE+T_HOLD+exec.
  - With defaults, N=22 for a normal byte and N=763 for a long one.
- Back-to-back: if in_valid is held high, the next accept happens on edge N+1. Maximum throughput is one byte per N+1 cycles.
- Reset mid-operation: e drops immediately and asynchronously, and the in-flight byte is lost. No done pulse is generated.
- rw is constant 0 in every state.

Decomposition:
- Shared package hd44780_pkg holds:
  - state enum {IDLE, SETUP, PULSE, HOLD, WAIT};
  - command constants CMD_CLEAR=8'h01 and CMD_HOME=8'h02;
  - default timing constants at CLOCK_FREQ 500000;
  - a function is_long_cmd(rs, byte).
- One sub-module: hd44780_delay_counter.
  - Inputs: load, load_value, clock, reset.
  - Output: zero.
  - The FSM remains in hd44780_bus_writer.

Test Plan:
- Reset asserted mid-PULSE (e=1) -> e, rs, db, in_ready go to 0 asynchronously, before the next edge; in_ready=1 one edge after release; no done pulse.
- Idle, then in_rs=1, in_data=8'h41, in_valid for one cycle:
  - rs=1 and db=8'h41 on edge 0;
  - e=1 only between edges 1 and 2;
  - done and in_ready on edge 22.
- in_rs=0, in_data=8'h01 (clear) -> e pulse as above; done at edge 763. Repeat with 8'h02 and 8'h03 -> 763; with 8'h04 and 8'h38 -> 22.
- in_rs=1, in_data=8'h01 (data, not command) -> done at edge 22, not 763.
- in_valid held high with a 3-byte sequence 8'h38, 8'h0C, 8'h06 -> accepts at edges 0, 23, 46; exactly three e pulses; each db stable from its accept edge through T_HOLD after e falls.
- in_data changed and in_valid toggled during WAIT -> no extra e pulse; db unchanged until the next accept.
